// File: rtl/sram_port_arbiter.sv
// Arbitrates NCH valid/ready request channels onto one single-port SRAM with a fixed read latency.
// Round-robin or fixed-priority grant; exactly one transaction is in flight at any time.
module sram_port_arbiter #(
   parameter int NCH       = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int RD_LAT    = 1,
   parameter int PRIO_MODE = 0,
   parameter int BE_W      = DATA_W/8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NCH-1:0]        req_valid,
   output logic [NCH-1:0]        req_ready,
   input  logic [NCH*BE_W-1:0]   req_wen,
   input  logic [NCH*ADDR_W-1:0] req_addr,
   input  logic [NCH*DATA_W-1:0] req_wdata,
   output logic [NCH-1:0]        resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  mem_en,
   output logic [BE_W-1:0]       mem_wen,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int LW = $clog2(RD_LAT+1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]        r_state;
   logic [LW-1:0]     r_lat_cnt;
   logic [IW-1:0]     r_rr_ptr;
   logic [IW-1:0]     r_rd_ch;
   logic [NCH-1:0]    r_ack;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   logic [NCH-1:0][IW-1:0] w_order;
   logic                   w_found;
   logic [IW-1:0]          w_gnt;
   logic                   w_hs;
   logic [BE_W-1:0]        w_wen;
   logic                   w_rd_done;

   // Search order: rr_ptr+1, rr_ptr+2, ... in round-robin, plain index order in fixed priority
   always_comb begin
      for (int k = 0; k < NCH; k++)
         w_order[k] = (PRIO_MODE == 1) ? IW'(k) : IW'((int'(r_rr_ptr) + 1 + k) % NCH);
   end

   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!w_found && req_valid[w_order[k]]) begin
            w_found = 1'b1;
            w_gnt   = w_order[k];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!reset && r_state == S_IDLE && w_found)
         req_ready[w_gnt] = 1'b1;
   end

   assign w_hs  = |(req_valid & req_ready);
   assign w_wen = req_wen[w_gnt*BE_W +: BE_W];

   // Address/data hold their last granted value while the port is idle
   assign mem_en    = w_hs;
   assign mem_wen   = w_hs ? w_wen : '0;
   assign mem_addr  = w_hs ? req_addr[w_gnt*ADDR_W +: ADDR_W] : r_addr;
   assign mem_wdata = w_hs ? req_wdata[w_gnt*DATA_W +: DATA_W] : r_wdata;

   assign w_rd_done = (r_state == S_WAIT) && (r_lat_cnt == '0);
   assign busy      = (r_state != S_IDLE);

   always_comb begin
      resp_valid = r_ack;
      resp_rdata = '0;
      if (w_rd_done) begin
         resp_valid[r_rd_ch] = 1'b1;
         resp_rdata          = mem_rdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lat_cnt <= '0;
         r_rr_ptr  <= IW'(NCH-1);
         r_rd_ch   <= '0;
         r_ack     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_addr  <= mem_addr;
                  r_wdata <= mem_wdata;
                  if (PRIO_MODE == 0)
                     r_rr_ptr <= w_gnt;
                  if (|w_wen) begin
                     r_ack <= req_ready;
                  end else begin
                     r_state   <= S_WAIT;
                     r_lat_cnt <= LW'(RD_LAT-1);
                     r_rd_ch   <= w_gnt;
                  end
               end
            end
            default: begin
               if (r_lat_cnt == '0)
                  r_state <= S_IDLE;
               else
                  r_lat_cnt <= r_lat_cnt - LW'(1);
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: four configurations, directed corner sequences, a vector table
// and a randomized run scored against a cycle-count/queue reference model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // A: NCH=4, RD_LAT=3, round-robin
   logic [3:0] a_valid, a_ready, a_resp;
   logic [31:0] a_wen;
   logic [127:0] a_addr;
   logic [255:0] a_wdata;
   logic [63:0] a_rdata, a_mwdata, a_mrdata;
   logic a_en, a_busy;
   logic [7:0] a_mwen;
   logic [31:0] a_maddr;
   logic [63:0] pa [3];
   sram_port_arbiter #(.NCH(4), .ADDR_W(32), .DATA_W(64), .RD_LAT(3), .PRIO_MODE(0)) u_a (
      .clock(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready), .req_wen(a_wen),
      .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp), .resp_rdata(a_rdata),
      .mem_en(a_en), .mem_wen(a_mwen), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
      .mem_rdata(a_mrdata), .busy(a_busy));
   always @(posedge clk) begin
      pa[0] <= {a_maddr, ~a_maddr};
      pa[1] <= pa[0];
      pa[2] <= pa[1];
   end
   assign a_mrdata = pa[2];

   // B: NCH=2, RD_LAT=2, round-robin, backed by a real byte-enabled memory
   logic [1:0] b_valid, b_ready, b_resp;
   logic [15:0] b_wen;
   logic [63:0] b_addr;
   logic [127:0] b_wdata;
   logic [63:0] b_rdata, b_mwdata, b_mrdata;
   logic b_en, b_busy;
   logic [7:0] b_mwen;
   logic [31:0] b_maddr;
   logic [63:0] pb [2];
   logic [63:0] memb [logic [31:0]];
   sram_port_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(64), .RD_LAT(2), .PRIO_MODE(0)) u_b (
      .clock(clk), .reset(rst), .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
      .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp), .resp_rdata(b_rdata),
      .mem_en(b_en), .mem_wen(b_mwen), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
      .mem_rdata(b_mrdata), .busy(b_busy));
   function automatic logic [63:0] memb_rd(input logic [31:0] a);
      if (memb.exists(a)) return memb[a];
      return {a, ~a};
   endfunction
   always @(posedge clk) begin
      logic [63:0] d;
      if (b_en && b_mwen != 8'h00) begin
         d = memb_rd(b_maddr);
         for (int j = 0; j < 8; j++) if (b_mwen[j]) d[j*8 +: 8] = b_mwdata[j*8 +: 8];
         memb[b_maddr] = d;
      end
      pb[0] <= memb_rd(b_maddr);
      pb[1] <= pb[0];
   end
   assign b_mrdata = pb[1];

   // C: NCH=3, RD_LAT=1, fixed priority
   logic [2:0] c_valid, c_ready, c_resp;
   logic [23:0] c_wen;
   logic [95:0] c_addr;
   logic [191:0] c_wdata;
   logic [63:0] c_rdata, c_mwdata, c_mrdata;
   logic c_en, c_busy;
   logic [7:0] c_mwen;
   logic [31:0] c_maddr;
   sram_port_arbiter #(.NCH(3), .ADDR_W(32), .DATA_W(64), .RD_LAT(1), .PRIO_MODE(1)) u_c (
      .clock(clk), .reset(rst), .req_valid(c_valid), .req_ready(c_ready), .req_wen(c_wen),
      .req_addr(c_addr), .req_wdata(c_wdata), .resp_valid(c_resp), .resp_rdata(c_rdata),
      .mem_en(c_en), .mem_wen(c_mwen), .mem_addr(c_maddr), .mem_wdata(c_mwdata),
      .mem_rdata(c_mrdata), .busy(c_busy));
   always @(posedge clk) c_mrdata <= {c_maddr, ~c_maddr};

   // D: NCH=2, RD_LAT=1, round-robin
   logic [1:0] d_valid, d_ready, d_resp;
   logic [15:0] d_wen;
   logic [63:0] d_addr;
   logic [127:0] d_wdata;
   logic [63:0] d_rdata, d_mwdata, d_mrdata;
   logic d_en, d_busy;
   logic [7:0] d_mwen;
   logic [31:0] d_maddr;
   sram_port_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(64), .RD_LAT(1), .PRIO_MODE(0)) u_d (
      .clock(clk), .reset(rst), .req_valid(d_valid), .req_ready(d_ready), .req_wen(d_wen),
      .req_addr(d_addr), .req_wdata(d_wdata), .resp_valid(d_resp), .resp_rdata(d_rdata),
      .mem_en(d_en), .mem_wen(d_mwen), .mem_addr(d_maddr), .mem_wdata(d_mwdata),
      .mem_rdata(d_mrdata), .busy(d_busy));
   always @(posedge clk) d_mrdata <= {d_maddr, ~d_maddr};

   typedef struct {
      logic [2:0]  valid;
      logic [23:0] wen;
      logic [2:0]  exp_ready;
      logic [7:0]  exp_mwen;
   } vec_t;
   vec_t tbl [8];

   typedef struct {
      int          due;
      int          ch;
      logic [63:0] data;
   } resp_t;
   resp_t q[$];
   logic [63:0] refmem [logic [31:0]];
   function automatic logic [63:0] ref_rd(input logic [31:0] a);
      if (refmem.exists(a)) return refmem[a];
      return {a, ~a};
   endfunction

   initial begin
      int cnt0, cnt1, prev, ngnt, cyc, free_at, last, g;
      logic [2:0] ph_valid [3];
      logic [2:0] ph_exp [3];
      logic [1:0] exp_ready, exp_resp, gnt_prev;
      logic [63:0] exp_data, wd;
      logic [7:0] wen;
      logic [31:0] ad;
      resp_t r;

      tbl[0] = '{3'b000, 24'h000000, 3'b000, 8'h00};
      tbl[1] = '{3'b100, 24'hFF0000, 3'b100, 8'hFF};
      tbl[2] = '{3'b110, 24'hFF0100, 3'b010, 8'h01};
      tbl[3] = '{3'b111, 24'h000080, 3'b001, 8'h80};
      tbl[4] = '{3'b011, 24'h000000, 3'b001, 8'h00};
      tbl[5] = '{3'b101, 24'h3C0000, 3'b001, 8'h00};
      tbl[6] = '{3'b110, 24'hFF0000, 3'b010, 8'h00};
      tbl[7] = '{3'b010, 24'h00AA00, 3'b010, 8'hAA};

      a_valid = '0; a_wen = '0; a_addr = '0; a_wdata = '0;
      c_valid = '0; c_wen = '0; c_addr = '0; c_wdata = '0;
      d_valid = '0; d_wen = '0; d_addr = {32'h200, 32'h100}; d_wdata = '0;
      b_valid = 2'b11; b_wen = 16'hFF00; b_addr = {32'h44, 32'h40}; b_wdata = '1;
      memb[32'h1000] = 64'hDEADBEEF_01234567;

      // reset state, with requests pending
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", b_ready, 2'b00);
      check("rst_resp", b_resp, 2'b00);
      check("rst_mem_en", b_en, 1'b0);
      check("rst_mem_wen", b_mwen, 8'h00);
      check("rst_mem_addr", b_maddr, 32'h0);
      check("rst_mem_wdata", b_mwdata, 64'h0);
      check("rst_busy", b_busy, 1'b0);
      @(negedge clk);
      rst = 1'b0; b_valid = '0; b_wen = '0;

      // read latency on B (RD_LAT=2)
      @(negedge clk);
      b_valid = 2'b10; b_addr[63:32] = 32'h1000;
      #1;
      check("lat_ready_T", b_ready, 2'b10);
      check("lat_mem_en_T", b_en, 1'b1);
      check("lat_mem_addr_T", b_maddr, 32'h1000);
      check("lat_mem_wen_T", b_mwen, 8'h00);
      @(negedge clk);
      b_valid = 2'b01; b_wen[7:0] = 8'h0F; b_addr[31:0] = 32'h20; b_wdata[63:0] = 64'h11223344;
      #1;
      check("lat_ready_T1", b_ready, 2'b00);
      check("lat_resp_T1", b_resp, 2'b00);
      check("lat_busy_T1", b_busy, 1'b1);
      check("lat_mem_en_T1", b_en, 1'b0);
      check("lat_addr_hold", b_maddr, 32'h1000);
      @(negedge clk);
      #1;
      check("lat_ready_T2", b_ready, 2'b00);
      check("lat_resp_T2", b_resp, 2'b10);
      check("lat_rdata_T2", b_rdata, 64'hDEADBEEF_01234567);

      // write ack and back-to-back grant
      @(negedge clk);
      b_valid = 2'b11; b_addr[63:32] = 32'h20;
      #1;
      check("wr_ready_T", b_ready, 2'b01);
      check("wr_mem_en_T", b_en, 1'b1);
      check("wr_mem_wen_T", b_mwen, 8'h0F);
      check("wr_mem_addr_T", b_maddr, 32'h20);
      check("wr_mem_wdata_T", b_mwdata, 64'h11223344);
      @(negedge clk);
      b_valid = 2'b10;
      #1;
      check("wr_ack_T1", b_resp, 2'b01);
      check("wr_ack_rdata_T1", b_rdata, 64'h0);
      check("wr_b2b_ready_T1", b_ready, 2'b10);
      check("wr_b2b_mem_wen_T1", b_mwen, 8'h00);
      @(negedge clk);
      b_valid = 2'b00;
      #1;
      check("wr_resp_T2", b_resp, 2'b00);
      @(negedge clk);
      #1;
      check("wr_rd_resp_T3", b_resp, 2'b10);
      check("wr_rd_rdata_T3", b_rdata, {32'h20, 32'h11223344});

      // reset mid-read on A (RD_LAT=3)
      @(negedge clk);
      a_valid = 4'b0001; a_addr[31:0] = 32'h80000000;
      #1;
      check("mr_ready_T", a_ready, 4'b0001);
      check("mr_mem_en_T", a_en, 1'b1);
      @(negedge clk);
      a_valid = 4'b0011; rst = 1'b1;
      #1;
      check("mr_busy_rst", a_busy, 1'b0);
      check("mr_mem_en_rst", a_en, 1'b0);
      check("mr_ready_rst", a_ready, 4'b0000);
      check("mr_resp_rst", a_resp, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mr_first_gnt", a_ready, 4'b0001);
      check("mr_resp_T2", a_resp, 4'b0000);
      @(negedge clk);
      a_valid = 4'b0000;
      #1;
      check("mr_resp_T3", a_resp, 4'b0000);
      @(negedge clk);
      #1;
      check("mr_resp_T4", a_resp, 4'b0000);
      @(negedge clk);
      #1;
      check("mr_new_resp", a_resp, 4'b0001);
      check("mr_new_rdata", a_rdata, {32'h80000000, 32'h7FFFFFFF});

      // wrap and cancel on A
      @(negedge clk);
      a_valid = 4'b1000; a_addr[127:96] = 32'h300;
      #1;
      check("wc_ready_ch3", a_ready, 4'b1000);
      @(negedge clk);
      a_valid = 4'b1000;
      #1;
      check("wc_ready_wait1", a_ready, 4'b0000);
      @(negedge clk);
      a_valid = 4'b0011;
      #1;
      check("wc_ready_wait2", a_ready, 4'b0000);
      @(negedge clk);
      #1;
      check("wc_resp_ch3", a_resp, 4'b1000);
      check("wc_rdata_ch3", a_rdata, {32'h300, 32'hFFFFFCFF});
      @(negedge clk);
      #1;
      check("wc_wrap_gnt", a_ready, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a_valid = 4'b0000;
         #1;
         check("wc_resp_after", a_resp, (i == 2) ? 4'b0001 : 4'b0000);
      end

      // round-robin fairness on D (RD_LAT=1)
      cnt0 = 0; cnt1 = 0; prev = -1;
      for (int i = 0; i < 400 && (cnt0 + cnt1) < 100; i++) begin
         @(negedge clk);
         d_valid = 2'b11;
         #1;
         if (d_ready != 2'b00) begin
            if (prev < 0) check("rr_first", d_ready, 2'b01);
            else check("rr_alt", d_ready, (prev == 0) ? 2'b10 : 2'b01);
            prev = d_ready[1] ? 1 : 0;
         end
         if (d_resp[0]) cnt0++;
         if (d_resp[1]) cnt1++;
      end
      check("rr_total", 64'(cnt0 + cnt1), 64'd100);
      check("rr_cnt0", 64'(cnt0), 64'd50);
      check("rr_cnt1", 64'(cnt1), 64'd50);
      @(negedge clk);
      d_valid = 2'b00;
      repeat (2) @(negedge clk);

      // vector table on C (fixed priority)
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         c_valid = tbl[i].valid; c_wen = tbl[i].wen;
         #1;
         check("tbl_ready", c_ready, tbl[i].exp_ready);
         check("tbl_mem_en", c_en, |tbl[i].exp_ready);
         check("tbl_mem_wen", c_mwen, tbl[i].exp_mwen);
         @(negedge clk);
         c_valid = 3'b000;
         #1;
         check("tbl_resp", c_resp, tbl[i].exp_ready);
         @(negedge clk);
         #1;
         check("tbl_idle_resp", c_resp, 3'b000);
         check("tbl_idle_busy", c_busy, 1'b0);
      end

      // fixed priority phases on C
      ph_valid[0] = 3'b111; ph_exp[0] = 3'b001;
      ph_valid[1] = 3'b110; ph_exp[1] = 3'b010;
      ph_valid[2] = 3'b100; ph_exp[2] = 3'b100;
      c_wen = '0;
      for (int p = 0; p < 3; p++) begin
         ngnt = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_valid = ph_valid[p];
            #1;
            if (c_ready != 3'b000) begin
               check("prio_gnt", c_ready, ph_exp[p]);
               ngnt++;
            end
         end
         check("prio_ngnt", 64'(ngnt), 64'd3);
      end
      @(negedge clk);
      c_valid = 3'b000;
      repeat (2) @(negedge clk);

      // randomized run on B against the reference model
      cyc = 0; free_at = 0; last = 1; gnt_prev = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            if (c >= 390 || (b_valid[ch] && gnt_prev[ch])) b_valid[ch] = 1'b0;
            else if (b_valid[ch]) begin
               if ($urandom_range(9) == 0) b_valid[ch] = 1'b0;
            end else if ($urandom_range(9) < 4) begin
               b_valid[ch] = 1'b1;
               b_wen[ch*8 +: 8] = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
               b_addr[ch*32 +: 32] = 32'h4000 + (32'($urandom_range(15)) << 3);
               b_wdata[ch*64 +: 64] = {$urandom, $urandom};
            end
         end
         #1;
         exp_ready = '0; gnt_prev = '0;
         if (cyc >= free_at) begin
            for (int k = 1; k <= 2; k++) begin
               int i;
               i = (last + k) % 2;
               if (b_valid[i] && exp_ready == 2'b00) exp_ready[i] = 1'b1;
            end
         end
         exp_resp = '0; exp_data = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            exp_resp[r.ch] = 1'b1;
            exp_data = r.data;
         end
         check("rnd_ready", b_ready, exp_ready);
         check("rnd_resp", b_resp, exp_resp);
         if (exp_resp != 2'b00) check("rnd_rdata", b_rdata, exp_data);
         if (exp_ready != 2'b00) begin
            g = exp_ready[1] ? 1 : 0;
            last = g; gnt_prev = exp_ready;
            wen = b_wen[g*8 +: 8]; ad = b_addr[g*32 +: 32];
            if (wen != 8'h00) begin
               wd = ref_rd(ad);
               for (int j = 0; j < 8; j++) if (wen[j]) wd[j*8 +: 8] = b_wdata[g*64 + j*8 +: 8];
               refmem[ad] = wd;
               q.push_back('{cyc + 1, g, 64'h0});
               free_at = cyc + 1;
            end else begin
               q.push_back('{cyc + 2, g, ref_rd(ad)});
               free_at = cyc + 3;
            end
         end
         cyc++;
      end
      check("rnd_drained", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
